adder_port_arbiter: RTL and testbench

Round-robin scheduler that shares one combinational signed adder (carry-bypass class, 32-bit, ports a/b/cin/sum/cout/overflow) between several requesters. It arbitrates valid/ready requests, drives the shared adder's operand lines, and captures the result into a single registered response slot with backpressure. It sits between the requester units and the adder instance, and is the only block permitted to drive that adder's inputs.

---
 rtl/adder_port_arbiter.sv | 121 ++++++++++++
 tb/tb_adder_port_arbiter.sv | 321 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/adder_port_arbiter.sv
// Round-robin scheduler that shares one combinational adder among N_REQ requesters
// and registers the result into a single response slot. Optional macro: ADDER_ARB_SUB_EN.
module adder_port_arbiter #(
  parameter  int N_REQ = 4,
  parameter  int WIDTH = 32,
  localparam int ID_W  = (N_REQ > 1) ? $clog2(N_REQ) : 1
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [N_REQ-1:0]       req_valid,
  output logic [N_REQ-1:0]       req_ready,
  input  logic [N_REQ*WIDTH-1:0] req_a,
  input  logic [N_REQ*WIDTH-1:0] req_b,
  input  logic [N_REQ-1:0]       req_cin,
`ifdef ADDER_ARB_SUB_EN
  input  logic [N_REQ-1:0]       req_sub,
`endif
  output logic [WIDTH-1:0]       add_a,
  output logic [WIDTH-1:0]       add_b,
  output logic                   add_cin,
  input  logic [WIDTH-1:0]       add_sum,
  input  logic                   add_cout,
  input  logic                   add_overflow,
  output logic                   rsp_valid,
  input  logic                   rsp_ready,
  output logic [ID_W-1:0]        rsp_id,
  output logic [WIDTH-1:0]       rsp_sum,
  output logic                   rsp_cout,
  output logic                   rsp_overflow,
  output logic [15:0]            txn_count
);

  localparam int SUM_W = ID_W + 1;

  typedef enum logic {
    EMPTY = 1'b0,
    FULL  = 1'b1
  } state_t;

  state_t           state;
  logic [ID_W-1:0]  ptr;
  logic [ID_W-1:0]  grant;
  logic [ID_W-1:0]  next_ptr;
  logic [SUM_W-1:0] cand;
  logic             any_valid;
  logic             can_accept;
  logic             accept;

  // Round-robin search starting at ptr; the first valid index found wins.
  always_comb begin
    // NOTE: every combinational output gets a default first so no path infers a latch.
    grant     = ptr;
    any_valid = 1'b0;
    cand      = '0;
    for (int off = 0; off < N_REQ; off++) begin
      cand = {1'b0, ptr} + SUM_W'(off);
      if (cand >= SUM_W'(N_REQ)) cand = cand - SUM_W'(N_REQ);
      if (!any_valid && req_valid[cand[ID_W-1:0]]) begin
        any_valid = 1'b1;
        grant     = cand[ID_W-1:0];
      end
    end
  end

  // Reset masks acceptance so no transaction slips in on a reset edge.
  assign can_accept = !rst && ((state == EMPTY) || rsp_ready);
  assign accept     = can_accept && any_valid;
  assign next_ptr   = (grant == ID_W'(N_REQ - 1)) ? '0 : grant + ID_W'(1);
  assign rsp_valid  = (state == FULL);

  always_comb begin
    req_ready = '0;
    if (accept) req_ready[grant] = 1'b1;
  end

  always_comb begin
    add_a   = '0;
    add_b   = '0;
    add_cin = 1'b0;
    if (any_valid) begin
      add_a = req_a[int'(grant)*WIDTH +: WIDTH];
`ifdef ADDER_ARB_SUB_EN
      if (req_sub[grant]) begin
        add_b   = ~req_b[int'(grant)*WIDTH +: WIDTH];
        add_cin = 1'b1;
      end else begin
        add_b   = req_b[int'(grant)*WIDTH +: WIDTH];
        add_cin = req_cin[grant];
      end
`else
      add_b   = req_b[int'(grant)*WIDTH +: WIDTH];
      add_cin = req_cin[grant];
`endif
    end
  end

  // Response slot FSM; refill takes priority over drain so rsp_valid stays high.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments only.
    if (rst) begin
      state        <= EMPTY;
      ptr          <= '0;
      rsp_id       <= '0;
      rsp_sum      <= '0;
      rsp_cout     <= 1'b0;
      rsp_overflow <= 1'b0;
      txn_count    <= '0;
    end else if (accept) begin
      state        <= FULL;
      ptr          <= next_ptr;
      rsp_id       <= grant;
      rsp_sum      <= add_sum;
      rsp_cout     <= add_cout;
      rsp_overflow <= add_overflow;
      txn_count    <= txn_count + 16'd1;
    end else if ((state == FULL) && rsp_ready) begin
      state <= EMPTY;
    end
  end

endmodule

// File: tb/tb_adder_port_arbiter.sv
// Self-checking bench for adder_port_arbiter: directed steps then randomized traffic,
// compared against an arithmetic reference model; includes a behavioural shared adder.
module tb_adder_port_arbiter;

  localparam int N   = 4;
  localparam int W   = 32;
  localparam int IDW = 2;

  logic           clk = 1'b0;
  logic           rst;
  logic [N-1:0]   req_valid;
  logic [N-1:0]   req_ready;
  logic [N*W-1:0] req_a;
  logic [N*W-1:0] req_b;
  logic [N-1:0]   req_cin;
`ifdef ADDER_ARB_SUB_EN
  logic [N-1:0]   req_sub;
`endif
  logic [W-1:0]   add_a, add_b, add_sum;
  logic           add_cin, add_cout, add_overflow;
  logic           rsp_valid, rsp_ready;
  logic [IDW-1:0] rsp_id;
  logic [W-1:0]   rsp_sum;
  logic           rsp_cout, rsp_overflow;
  logic [15:0]    txn_count;

  int checks   = 0;
  int failures = 0;

  logic [W-1:0] op_a [N];
  logic [W-1:0] op_b [N];

  // Reference model state
  bit           m_full;
  int           m_ptr;
  int           m_id;
  logic [W-1:0] m_sum;
  bit           m_cout, m_ovf;
  int           m_txn;
  bit           last_acc;
  int           last_g;

  always #5 clk = ~clk;

  // Shared combinational adder attached to the arbiter
  logic [W:0] adder_full;
  assign adder_full   = {1'b0, add_a} + {1'b0, add_b} + {{W{1'b0}}, add_cin};
  assign add_sum      = adder_full[W-1:0];
  assign add_cout     = adder_full[W];
  assign add_overflow = (add_a[W-1] == add_b[W-1]) && (add_sum[W-1] != add_a[W-1]);

  adder_port_arbiter #(.N_REQ(N), .WIDTH(W)) dut (
    .clk         (clk),
    .rst         (rst),
    .req_valid   (req_valid),
    .req_ready   (req_ready),
    .req_a       (req_a),
    .req_b       (req_b),
    .req_cin     (req_cin),
`ifdef ADDER_ARB_SUB_EN
    .req_sub     (req_sub),
`endif
    .add_a       (add_a),
    .add_b       (add_b),
    .add_cin     (add_cin),
    .add_sum     (add_sum),
    .add_cout    (add_cout),
    .add_overflow(add_overflow),
    .rsp_valid   (rsp_valid),
    .rsp_ready   (rsp_ready),
    .rsp_id      (rsp_id),
    .rsp_sum     (rsp_sum),
    .rsp_cout    (rsp_cout),
    .rsp_overflow(rsp_overflow),
    .txn_count   (txn_count)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Result of requester g computed with plain 64-bit integer arithmetic.
  task automatic expected_result(input int g, output logic [W-1:0] s, output bit c, output bit o);
    longint ua, ub, usum, sa, sb, ssum, sext;
    bit sub;
    sub = 1'b0;
`ifdef ADDER_ARB_SUB_EN
    sub = req_sub[g];
`endif
    ua = {32'd0, op_a[g]};
    ub = {32'd0, op_b[g]};
    sa = $signed({{32{op_a[g][W-1]}}, op_a[g]});
    sb = $signed({{32{op_b[g][W-1]}}, op_b[g]});
    if (sub) begin
      usum = ua - ub;
      c    = (ua >= ub);
      ssum = sa - sb;
    end else begin
      usum = ua + ub + longint'(req_cin[g]);
      c    = (usum >= 64'h1_0000_0000);
      ssum = sa + sb + longint'(req_cin[g]);
    end
    s    = usum[W-1:0];
    sext = $signed({{32{s[W-1]}}, s});
    o    = (ssum != sext);
  endtask

  // One clock: check combinational outputs, advance model across the edge, check registers.
  task automatic step();
    int           g;
    bit           can_acc;
    logic [N-1:0] exp_ready;
    logic [W-1:0] ea, eb, ns;
    bit           ec, nc, no;
    for (int i = 0; i < N; i++) begin
      req_a[i*W +: W] = op_a[i];
      req_b[i*W +: W] = op_b[i];
    end
    #1;
    g = -1;
    for (int k = 0; k < N; k++) begin
      if (g < 0 && req_valid[(m_ptr + k) % N]) g = (m_ptr + k) % N;
    end
    can_acc   = !rst && (!m_full || rsp_ready);
    exp_ready = '0;
    ea = '0; eb = '0; ec = 1'b0;
    ns = '0; nc = 1'b0; no = 1'b0;
    if (g >= 0) begin
      if (can_acc) exp_ready[g] = 1'b1;
      ea = op_a[g];
      eb = op_b[g];
      ec = req_cin[g];
`ifdef ADDER_ARB_SUB_EN
      if (req_sub[g]) begin
        eb = ~op_b[g];
        ec = 1'b1;
      end
`endif
      expected_result(g, ns, nc, no);
    end
    check("req_ready", req_ready, exp_ready);
    check("add_a", add_a, ea);
    check("add_b", add_b, eb);
    check("add_cin", add_cin, ec);
    @(posedge clk);
    last_acc = can_acc && (g >= 0);
    last_g   = g;
    if (rst) begin
      m_full = 0; m_ptr = 0; m_id = 0; m_sum = '0; m_cout = 0; m_ovf = 0; m_txn = 0;
    end else if (last_acc) begin
      m_full = 1;
      m_id   = g;
      m_sum  = ns;
      m_cout = nc;
      m_ovf  = no;
      m_ptr  = (g + 1) % N;
      m_txn  = (m_txn + 1) % 65536;
    end else if (m_full && rsp_ready) begin
      m_full = 0;
    end
    #1;
    check("rsp_valid", rsp_valid, m_full);
    check("txn_count", txn_count, m_txn);
    if (m_full) begin
      check("rsp_id", rsp_id, m_id);
      check("rsp_sum", rsp_sum, m_sum);
      check("rsp_cout", rsp_cout, m_cout);
      check("rsp_overflow", rsp_overflow, m_ovf);
    end
  endtask

  function automatic logic [W-1:0] rand_operand();
    case ($urandom_range(0, 5))
      0:       return 32'h7fff_ffff;
      1:       return 32'h8000_0000;
      2:       return 32'hffff_ffff;
      3:       return 32'h0000_0000;
      default: return $urandom;
    endcase
  endfunction

  initial begin
    rst       = 1'b1;
    req_valid = '1;
    req_cin   = '0;
`ifdef ADDER_ARB_SUB_EN
    req_sub   = '0;
`endif
    rsp_ready = 1'b0;
    for (int i = 0; i < N; i++) begin
      op_a[i] = '0;
      op_b[i] = '0;
    end
    m_full = 0; m_ptr = 0; m_id = 0; m_sum = '0; m_cout = 0; m_ovf = 0; m_txn = 0;
    last_acc = 0; last_g = -1;

    // Reset with requests pending: nothing accepted, all outputs cleared
    @(posedge clk); #1;
    step();
    step();
    check("reset_rsp_valid", rsp_valid, 1'b0);
    check("reset_rsp_id", rsp_id, 0);
    check("reset_rsp_sum", rsp_sum, 0);
    check("reset_txn", txn_count, 0);
    rst       = 1'b0;
    req_valid = '0;
    step();

    // Single request on port 2: 100 + (-50)
    op_a[2]   = 32'd100;
    op_b[2]   = -32'sd50;
    req_valid = 4'b0100;
    step();
    check("t1_valid", rsp_valid, 1'b1);
    check("t1_sum", rsp_sum, 32'd50);
    check("t1_id", rsp_id, 2);
    check("t1_txn", txn_count, 1);
    req_valid = '0;
    rsp_ready = 1'b1;
    step();
    rst = 1'b1;
    step();
    rst = 1'b0;

    // All four requesting every cycle: rotation 0,1,2,3,0
    for (int i = 0; i < N; i++) begin
      op_a[i] = 32'd1000 * (i + 1);
      op_b[i] = 32'd7 + i;
    end
    req_valid = 4'b1111;
    for (int k = 0; k < 5; k++) begin
      step();
      check("rr_id", rsp_id, k % N);
      check("rr_valid", rsp_valid, 1'b1);
    end

    // Signed overflow corners
    op_a[0]   = 32'h7fff_ffff;
    op_b[0]   = 32'd1;
    req_valid = 4'b0001;
    step();
    check("ovf0_sum", rsp_sum, 32'h8000_0000);
    check("ovf0_flag", rsp_overflow, 1'b1);
    op_a[1]   = 32'h8000_0000;
    op_b[1]   = 32'hffff_ffff;
    req_valid = 4'b0010;
    step();
    check("ovf1_sum", rsp_sum, 32'h7fff_ffff);
    check("ovf1_flag", rsp_overflow, 1'b1);
    check("ovf1_cout", rsp_cout, 1'b1);

    // Backpressure for three cycles, then drain and refill at one edge
    rsp_ready = 1'b0;
    op_a[2]   = 32'd5;
    op_b[2]   = 32'd6;
    req_valid = 4'b0100;
    for (int k = 0; k < 3; k++) begin
      step();
      check("bp_sum_held", rsp_sum, 32'h7fff_ffff);
      check("bp_ready_low", req_ready, 4'b0000);
    end
    rsp_ready = 1'b1;
    step();
    check("refill_valid", rsp_valid, 1'b1);
    check("refill_id", rsp_id, 2);
    check("refill_sum", rsp_sum, 32'd11);

    // Reset while FULL with requests pending
    rsp_ready = 1'b0;
    req_valid = 4'b1111;
    rst       = 1'b1;
    step();
    check("rst_full_valid", rsp_valid, 1'b0);
    check("rst_full_txn", txn_count, 0);
    rst       = 1'b0;
    rsp_ready = 1'b1;
    req_valid = 4'b0110;
    step();
    check("post_rst_id", rsp_id, 1);

`ifdef ADDER_ARB_SUB_EN
    // Subtract: 200 - 150
    op_a[0]    = 32'd200;
    op_b[0]    = 32'd150;
    req_sub[0] = 1'b1;
    req_valid  = 4'b0001;
    step();
    check("sub_sum", rsp_sum, 32'd50);
    check("sub_cout", rsp_cout, 1'b1);
    req_sub[0] = 1'b0;
`endif

    // Randomized traffic; unaccepted requests hold their operands
    req_valid = '0;
    for (int n = 0; n < 400; n++) begin
      for (int i = 0; i < N; i++) begin
        if (!req_valid[i] || (last_acc && last_g == i)) begin
          req_valid[i] = ($urandom_range(0, 2) != 0);
          op_a[i]      = rand_operand();
          op_b[i]      = rand_operand();
          req_cin[i]   = 1'($urandom_range(0, 1));
`ifdef ADDER_ARB_SUB_EN
          req_sub[i]   = 1'($urandom_range(0, 1));
`endif
        end
      end
      rsp_ready = ($urandom_range(0, 3) != 0);
      rst       = ($urandom_range(0, 49) == 0);
      step();
    end
    rst = 1'b0;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
